// File: rtl/grf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_write_arbiter_pkg
// Description : Shared widths and requester identifiers for the register-file
//               write arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_write_arbiter_pkg;

  // Default register file geometry: 32 registers of 32 bits.
  localparam int c_grf_addr_w = 5;
  localparam int c_grf_data_w = 32;

  // Requester identity; also the encoding of the round-robin pointer, which
  // remembers the requester granted most recently.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // The other requester, used to express "the one not granted last".
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage : grf_write_arbiter_pkg
`default_nettype wire

// File: rtl/grf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : grf_write_arbiter_if
// Description : Bundle of the two requester ports, the register-file write
//               port and the bypass lookup port of the write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface grf_write_arbiter_if
  import grf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_grf_addr_w,
  parameter int DATA_W = c_grf_data_w
);

  // Requester A (pipeline writeback)
  logic              A_Valid;
  logic [ADDR_W-1:0] A_Addr;
  logic [DATA_W-1:0] A_Data;
  logic              A_Ready;

  // Requester B (multi-cycle unit)
  logic              B_Valid;
  logic [ADDR_W-1:0] B_Addr;
  logic [DATA_W-1:0] B_Data;
  logic              B_Ready;

  // Registered write port into the register file
  logic              GRF_WEnable;
  logic [ADDR_W-1:0] GRF_WAddr;
  logic [DATA_W-1:0] GRF_WData;

  // Bypass lookup against the staged write
  logic [ADDR_W-1:0] Byp_RAddr1;
  logic [ADDR_W-1:0] Byp_RAddr2;
  logic              Byp_Hit1;
  logic              Byp_Hit2;
  logic [DATA_W-1:0] Byp_Data1;
  logic [DATA_W-1:0] Byp_Data2;

  // Requesters and read-port logic: drive requests and lookup addresses.
  modport master (
    output A_Valid, A_Addr, A_Data,
    output B_Valid, B_Addr, B_Data,
    output Byp_RAddr1, Byp_RAddr2,
    input  A_Ready, B_Ready,
    input  GRF_WEnable, GRF_WAddr, GRF_WData,
    input  Byp_Hit1, Byp_Hit2, Byp_Data1, Byp_Data2
  );

  // The arbiter itself.
  modport slave (
    input  A_Valid, A_Addr, A_Data,
    input  B_Valid, B_Addr, B_Data,
    input  Byp_RAddr1, Byp_RAddr2,
    output A_Ready, B_Ready,
    output GRF_WEnable, GRF_WAddr, GRF_WData,
    output Byp_Hit1, Byp_Hit2, Byp_Data1, Byp_Data2
  );

endinterface : grf_write_arbiter_if
`default_nettype wire

// File: rtl/grf_write_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Purely combinational two-way round-robin arbiter. A lone
//               request is always granted; on a tie the requester that was
//               not granted most recently wins. Grants are one-hot or zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import grf_write_arbiter_pkg::*;
(
  input  wire logic    i_req_a,
  input  wire logic    i_req_b,
  input  wire req_id_e i_last,
  output logic         o_gnt_a,
  output logic         o_gnt_b
);

  logic w_tie;

  assign w_tie = i_req_a & i_req_b;

  // Resolve the grant: lone requests win outright, ties go to the other side.
  always_comb begin
    o_gnt_a = 1'b0;
    o_gnt_b = 1'b0;
    if (w_tie) begin
      if (other_req(i_last) == REQ_A) begin
        o_gnt_a = 1'b1;
      end else begin
        o_gnt_b = 1'b1;
      end
    end else begin
      o_gnt_a = i_req_a;
      o_gnt_b = i_req_b;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grf_write_arbiter
// Description : Merges writes from the pipeline writeback (A) and a
//               multi-cycle unit (B) into the single register-file write
//               port. One request is accepted per cycle, staged for exactly
//               one cycle, and exposed both as the write port and as a
//               bypass source for two read addresses. Register 0 is never
//               written and never bypassed.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_write_arbiter
  import grf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = c_grf_addr_w,
  parameter int DATA_W = c_grf_data_w
) (
  input  wire logic          clk,
  input  wire logic          reset,
  grf_write_arbiter_if.slave bus
);

  // Requests masked by reset so nothing is accepted while reset is held.
  logic              w_req_a;
  logic              w_req_b;
  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [DATA_W-1:0] w_nxt_data;
  logic              w_stg_live;

  // Stage register and round-robin pointer.
  logic              r_stg_valid;
  logic [ADDR_W-1:0] r_stg_addr;
  logic [DATA_W-1:0] r_stg_data;
  req_id_e           r_last;

  assign w_req_a = bus.A_Valid & ~reset;
  assign w_req_b = bus.B_Valid & ~reset;

  rr_arb2 u_rr_arb2 (
    .i_req_a (w_req_a),
    .i_req_b (w_req_b),
    .i_last  (r_last),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign bus.A_Ready = w_gnt_a;
  assign bus.B_Ready = w_gnt_b;
  assign w_any_gnt   = w_gnt_a | w_gnt_b;

  // Select the payload of the granted requester for the stage register.
  always_comb begin
    w_nxt_addr = bus.A_Addr;
    w_nxt_data = bus.A_Data;
    if (w_gnt_b) begin
      w_nxt_addr = bus.B_Addr;
      w_nxt_data = bus.B_Data;
    end
  end

  // Stage register and pointer: capture on grant, drain every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stg_valid <= 1'b0;
      r_stg_addr  <= '0;
      r_stg_data  <= '0;
      r_last      <= REQ_B;
    end else begin
      r_stg_valid <= w_any_gnt;
      if (w_any_gnt) begin
        // Address and data hold their last value on idle cycles.
        r_stg_addr <= w_nxt_addr;
        r_stg_data <= w_nxt_data;
        r_last     <= w_gnt_b ? REQ_B : REQ_A;
      end
    end
  end

  // A staged write to register 0 is swallowed: no enable, no bypass.
  assign w_stg_live = r_stg_valid & (r_stg_addr != '0);

  assign bus.GRF_WEnable = w_stg_live;
  assign bus.GRF_WAddr   = r_stg_addr;
  assign bus.GRF_WData   = r_stg_data;

  // Bypass: forward the staged data to any matching nonzero read address.
  always_comb begin
    bus.Byp_Hit1  = w_stg_live & (r_stg_addr == bus.Byp_RAddr1);
    bus.Byp_Hit2  = w_stg_live & (r_stg_addr == bus.Byp_RAddr2);
    bus.Byp_Data1 = bus.Byp_Hit1 ? r_stg_data : '0;
    bus.Byp_Data2 = bus.Byp_Hit2 ? r_stg_data : '0;
  end

endmodule : grf_write_arbiter
`default_nettype wire
